// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store sequencer for a 32-bit little-endian byte-addressed RAM.
// Define MAU_SUBWORD_EN for byte/halfword accesses (read-modify-write stores); undefined means word-only.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        store,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_data
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state, state_nx;
    logic [31:0] addr_q;
    logic [31:0] wbuf;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        bad;
    logic        word_store;

    assign word_store = store && (size == SZ_WORD);

`ifdef MAU_SUBWORD_EN
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        store_q;
    logic        uns_q;
    logic [15:0] wdata_q;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] sz, input logic zext);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: r = zext ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = zext ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] sz, input logic [15:0] wd);
        logic [31:0] r;
        r = word;
        if (sz == SZ_BYTE)
            r[{lane, 3'b000} +: 8] = wd[7:0];
        else if (lane[1])
            r[31:16] = wd;
        else
            r[15:0] = wd;
        return r;
    endfunction

    assign bad = (size == 2'b11) || ((size == SZ_HALF) && addr[0]) ||
                 ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
    logic unused_uns;
    assign unused_uns = uns;
    // Word-only build: anything but an aligned word is rejected up front.
    assign bad = (size != SZ_WORD) || (addr[1:0] != 2'b00);
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad)
                        state_nx = DONE;
                    else if (word_store)
                        state_nx = WRITE;
                    else
                        state_nx = READ;
                end
            end
`ifdef MAU_SUBWORD_EN
            READ:    state_nx = store_q ? WRITE : DONE;
`else
            READ:    state_nx = DONE;
`endif
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wbuf    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MAU_SUBWORD_EN
            lane_q  <= '0;
            size_q  <= '0;
            store_q <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= {addr[31:2], 2'b00};
                        err_q  <= bad;
                        if (!bad && word_store)
                            wbuf <= wdata;
`ifdef MAU_SUBWORD_EN
                        lane_q  <= addr[1:0];
                        size_q  <= size;
                        store_q <= store;
                        uns_q   <= uns;
                        wdata_q <= wdata[15:0];
`endif
                    end
                end
                READ: begin
`ifdef MAU_SUBWORD_EN
                    if (store_q)
                        wbuf <= store_merge(mem_data, lane_q, size_q, wdata_q);
                    else
                        rdata_q <= load_extend(mem_data, lane_q, size_q, uns_q);
`else
                    rdata_q <= mem_data;
`endif
                end
                default: ;
            endcase
        end
    end

    // RAM-side outputs depend only on state and latched registers.
    assign ready    = (state == IDLE);
    assign done     = (state == DONE);
    assign err      = done && err_q;
    assign rdata    = rdata_q;
    assign mem_we   = (state == WRITE);
    assign mem_addr = addr_q;
    assign mem_wd   = mem_we ? wbuf : 32'd0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural RAM plus an arithmetic model of each operation's result and timing.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst, req, store, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_wd, mem_data;
    logic        ready, done, err, mem_we;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .req(req), .store(store), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
        .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_data(mem_data)
    );

`ifdef MAU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic [31:0] ram     [0:255];
    logic [31:0] mdl_mem [0:255];
    assign mem_data = ram[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) ram[mem_addr[9:2]] <= mem_wd;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl_rdata;
    bit          op_active = 1'b0, done_seen = 1'b0, aborting = 1'b0;
    int          op_cyc, we_seen, exp_lat, exp_we_cnt, lat_obs;
    bit          exp_err;
    logic [31:0] exp_wd, exp_wa;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outcome from byte-level arithmetic on the model memory.
    function automatic void model_op(input bit st, input logic [1:0] sz, input bit un,
                                     input logic [31:0] a, input logic [31:0] wd);
        int nb, o;
        bit ok;
        logic [31:0] mask, old, v;
        nb = 1 << sz;
        ok = (sz == 2'd2) || (SUBWORD && sz != 2'd3);
        if (ok && ((a & (nb - 1)) != 0)) ok = 1'b0;
        exp_err = !ok;
        exp_we_cnt = 0;
        exp_wd = 32'd0;
        exp_wa = a & ~32'h3;
        if (!ok) begin
            exp_lat = 1;
            return;
        end
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        o = int'(a[1:0]);
        old = mdl_mem[a[9:2]];
        if (!st) begin
            v = (old >> (8 * o)) & mask;
            if (!un && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
            mdl_rdata = v;
            exp_lat = 2;
        end else begin
            v = (old & ~(mask << (8 * o))) | ((wd & mask) << (8 * o));
            mdl_mem[a[9:2]] = v;
            exp_wd = v;
            exp_we_cnt = 1;
            exp_lat = (nb == 4) ? 2 : 3;
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
        end else if (op_active) begin
            op_cyc++;
            chk("busy_ready", ready, 32'd0);
            if (mem_we) begin
                we_seen++;
                chk("we_cycle", op_cyc, exp_lat - 1);
                chk("mem_addr", mem_addr, exp_wa);
                chk("mem_wd", mem_wd, exp_wd);
            end else begin
                chk("wd_quiet", mem_wd, 32'd0);
            end
            if (done) begin
                chk("latency", op_cyc, exp_lat);
                chk("err", err, exp_err);
                chk("rdata", rdata, mdl_rdata);
                chk("we_count", we_seen, exp_we_cnt);
                lat_obs = op_cyc;
                done_seen = 1'b1;
                op_active = 1'b0;
            end
        end else begin
            chk("idle_done", done, 32'd0);
            chk("idle_we", mem_we, 32'd0);
            if (!aborting) chk("idle_ready", ready, 32'd1);
        end
    end

    task automatic run_op(input bit st, input logic [1:0] sz, input bit un,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold = 1'b0);
        model_op(st, sz, un, a, wd);
        done_seen = 1'b0;
        we_seen = 0;
        @(posedge clk); #2;
        req = 1'b1; store = st; size = sz; uns = un; addr = a; wdata = wd;
        @(posedge clk); #2;
        op_cyc = 0;
        op_active = 1'b1;
        if (hold) begin
            store = ~st; wdata = ~wd; addr = a ^ 32'h4;
            @(posedge clk); #2;
        end
        req = 1'b0;
        for (int i = 0; i < 10 && !done_seen; i++) @(posedge clk);
        #2;
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen, got none expected after %0d cycles", exp_lat);
            op_active = 1'b0;
        end
        if (st && !exp_err) chk("ram_word", ram[a[9:2]], mdl_mem[a[9:2]]);
    endtask

    task automatic abort_op(input bit st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #2;
        req = 1'b1; store = st; size = sz; uns = 1'b0; addr = a; wdata = wd;
        @(posedge clk); #2;
        req = 1'b0;
        aborting = 1'b1;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        aborting = 1'b0;
        mdl_rdata = 32'd0;
        @(negedge clk);
        chk("abort_ready", ready, 32'd1);
        chk("abort_we", mem_we, 32'd0);
        chk("abort_done", done, 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_ram", ram[a[9:2]], mdl_mem[a[9:2]]);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; store = 1'b0; size = 2'b10; uns = 1'b0;
        addr = 32'd0; wdata = 32'd0; mdl_rdata = 32'd0; lat_obs = 0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'h0 + i;
            mdl_mem[i] = 32'h0 + i;
        end
        ram[8'h40] = 32'h8899AABB;
        mdl_mem[8'h40] = 32'h8899AABB;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 32'd1);
        chk("rst_done", done, 32'd0);
        chk("rst_err", err, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_we", mem_we, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wd", mem_wd, 32'd0);

        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        chk("lit_word_load", rdata, 32'h8899AABB);
        chk("lit_word_lat", lat_obs, 32'd2);
`ifdef MAU_SUBWORD_EN
        run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        chk("lit_sbyte", rdata, 32'hFFFFFF88);
        run_op(1'b0, 2'b00, 1'b1, 32'h102, 32'h0);
        chk("lit_ubyte", rdata, 32'h00000099);
        run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        chk("lit_shalf", rdata, 32'hFFFF8899);
        run_op(1'b0, 2'b01, 1'b1, 32'h100, 32'h0);
        chk("lit_uhalf", rdata, 32'h0000AABB);
        run_op(1'b1, 2'b00, 1'b0, 32'h101, 32'h1234565A);
        chk("lit_bstore_lat", lat_obs, 32'd3);
        chk("lit_bstore_ram", ram[8'h40], 32'h88995ABB);
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
        chk("lit_reload", rdata, 32'h88995ABB);
        run_op(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        chk("lit_misalign_lat", lat_obs, 32'd1);
        chk("lit_misalign_rdata", rdata, 32'h88995ABB);
        run_op(1'b1, 2'b01, 1'b0, 32'h101, 32'hBEEF);
        chk("lit_hstore_err_ram", ram[8'h40], 32'h88995ABB);
        run_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000CAFE);
        chk("lit_hstore_ram", ram[8'h40], 32'hCAFE5ABB);
        abort_op(1'b1, 2'b00, 32'h101, 32'h77);
        chk("lit_abort_ram", ram[8'h40], 32'hCAFE5ABB);
        chk("lit_abort_rdata", rdata, 32'd0);
        run_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        run_op(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF);
        run_op(1'b0, 2'b00, 1'b0, 32'h107, 32'h0);
        chk("lit_sbyte_de", rdata, 32'hFFFFFFDE);
`else
        run_op(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
        chk("lit_byte_rej_lat", lat_obs, 32'd1);
        chk("lit_byte_rej_rdata", rdata, 32'h8899AABB);
        run_op(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        run_op(1'b1, 2'b01, 1'b0, 32'h101, 32'h1234);
        chk("lit_hstore_rej_ram", ram[8'h40], 32'h8899AABB);
        run_op(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        chk("lit_wstore_lat", lat_obs, 32'd2);
        chk("lit_wstore_ram", ram[8'h40], 32'hDEADBEEF);
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
        chk("lit_reload", rdata, 32'hDEADBEEF);
        run_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        abort_op(1'b0, 2'b10, 32'h104, 32'h0);
        chk("lit_abort_rdata", rdata, 32'd0);
        run_op(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
        chk("lit_load_41", rdata, 32'h00000041);
        run_op(1'b1, 2'b10, 1'b0, 32'h108, 32'h13579BDF);
        run_op(1'b0, 2'b10, 1'b0, 32'h108, 32'h0);
        chk("lit_load_108", rdata, 32'h13579BDF);
`endif
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the core's execute stage and the byte-addressed 32-bit data RAM. It accepts one memory operation at a time from the core and sequences it onto the RAM port. The RAM port has a combinational read, a posedge write of all four byte lanes, and little-endian byte order. Sub-word stores are done as read-modify-write; sub-word loads are lane-extracted and sign- or zero-extended.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  1  operation request; sampled only when ready=1
- store  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 invalid
- uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ready  out  1  unit idle, can accept req
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = operation rejected, no RAM access
- rdata  out  32  load result; updated only on a successful load's done, held otherwise
- mem_we  out  1  RAM write enable
- mem_addr  out  32  RAM byte address, always word-aligned (addr & ~3)
- mem_wd  out  32  RAM write data
- mem_data  in  32  RAM combinational read data for mem_addr

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: ready=1. On req, latch addr, wdata, size, store and uns, then check the request:
  - Invalid size, halfword with addr[0]=1, or word with addr[1:0]≠0 → DONE with err=1.
  - Otherwise: a load or a sub-word store → READ; a word store → WRITE.
- READ: mem_addr = aligned address, mem_we=0, mem_data captured at the edge.
  - Load: extract the lane. Byte lane = addr[1:0] (lane 0 = mem_data[7:0]). Half lane = addr[1] (0 → [15:0]). Extend per uns, write rdata, go to DONE.
  - Sub-word store: merge wdata's low byte or half into the captured word at the lane, store the result in the write buffer, go to WRITE.
- WRITE: mem_we=1, mem_addr = aligned address, mem_wd = write buffer (word store: wdata). Go to DONE.
- DONE: done=1 and err valid, for exactly one cycle. Go to IDLE.
- mem_we, mem_addr and mem_wd are functions of state and latched registers only. There is no combinational path from core inputs to RAM outputs.
- Outside WRITE: mem_we=0 and mem_wd=0. mem_addr holds the last latched aligned address.
- req while ready=0 is ignored, not queued.

## Timing
- Cycle 0 is the edge at which req is sampled in IDLE. done is asserted in the cycle after:
  - error: edge 1
  - load: edge 2
  - word store: edge 2
  - sub-word store: edge 3
- ready deasserts the cycle after acceptance and reasserts the cycle after DONE. Minimum spacing between accepted requests = latency + 1.
- A store is visible in RAM from the edge ending WRITE. Exactly one mem_we cycle per successful store; none for loads or errors.
- Reset values: state IDLE, ready=1, done=0, err=0, rdata=0, mem_we=0, mem_addr=0, mem_wd=0, write buffer=0.
- rst mid-operation: state returns to IDLE at that edge and mem_we is 0 in the following cycle. A store not yet in WRITE is abandoned and RAM is unchanged. No done is produced for the aborted operation.
- rst and req in the same cycle: rst wins, request dropped.

## Configuration
- MAU_SUBWORD_EN defined: byte and halfword loads and stores are supported as above.
- MAU_SUBWORD_EN undefined: only word accesses are supported.
  - size 00 or 01 is rejected like size 11 (DONE with err=1, latency 1).
  - The READ path for stores, the merge logic and the extension logic are removed.
  - Word loads and word stores keep identical timing.

## Test plan
- RAM preloaded with 0x8899AABB at 0x100. Word load 0x100 → done at edge 2, rdata=0x8899AABB, err=0, mem_we never 1.
- Signed byte load at 0x103 → rdata=0xFFFFFF88. Unsigned byte load at 0x102 → 0x00000099. Signed half load at 0x102 → 0xFFFF8899.
- Byte store wdata=0x1234565A at 0x101 → one mem_we cycle with mem_addr=0x100, mem_wd=0x88995ABB. done at edge 3. Following word load returns 0x88995ABB.
- Word load at 0x102 → done and err=1 at edge 1, mem_we never asserted, rdata unchanged. Half store at 0x101 → same behaviour.
- Byte store accepted, rst asserted in the READ cycle → no mem_we pulse, ready=1 the cycle after the reset edge, word at 0x100 unchanged, no done.
- Built without MAU_SUBWORD_EN: byte load at 0x100 → err=1 at edge 1. Word store 0xDEADBEEF at 0x100 → done at edge 2, RAM reads 0xDEADBEEF.
